bank_stream_reader: RTL and testbench
=====================================

BANK_STREAM_READER -- requirements
Module: bank_stream_reader

Interface
REQ-001 Parameter NUM_RAMS, default 8: number of parallel RAM banks.
REQ-002 Parameter W, default 128: data width per bank, in bits.
REQ-003 Parameter D, default 128: depth per bank, in words.
REQ-004 Parameter FIFO_DEPTH, default 4: output buffer depth; power of two, at least 2.
REQ-005 Port clk, input, 1 bit: the single clock for all logic.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port cmd_valid, input, 1 bit: command request.
REQ-008 Port cmd_ready, output, 1 bit: block can accept a command.
REQ-009 Port cmd_base, input, 32 bits: starting row address; must be less than D.
REQ-010 Port cmd_stride, input, 32 bits: row increment; must be less than D.
REQ-011 Port cmd_len, input, 16 bits: number of rows to read.
REQ-012 Port ram_re, output, 1 bit: read enable to the banked RAM.
REQ-013 Port ram_read_addr, output, NUM_RAMS*32 bits: per-bank read address; bank i uses bits [32i+31:32i].
REQ-014 Port ram_dout_vld, input, 1 bit: RAM read data valid.
REQ-015 Port ram_dout, input, NUM_RAMS*W bits: RAM read data.
REQ-016 Port m_valid, output, 1 bit: output beat valid.
REQ-017 Port m_ready, input, 1 bit: downstream accepts the beat.
REQ-018 Port m_data, output, NUM_RAMS*W bits: one row across all banks.
REQ-019 Port m_last, output, 1 bit: marks the final beat of a command.
REQ-020 Port busy, output, 1 bit: a command is in progress.
REQ-021 Port done, output, 1 bit: one-cycle pulse at command completion.

Function
REQ-022 The FSM SHALL have three states: IDLE, ISSUE and DRAIN.
REQ-023 cmd_ready SHALL be 1 only in IDLE.
REQ-024 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both 1; base, stride and len are latched on that edge.
REQ-025 On acceptance with cmd_len greater than 0, the FSM SHALL go IDLE -> ISSUE, with the row pointer set to cmd_base and the issue counter set to cmd_len.
REQ-026 On acceptance with cmd_len equal to 0, the FSM SHALL stay in IDLE, issue no reads, and pulse done one cycle later with no m_valid.
REQ-027 In ISSUE, ram_re SHALL be 1 exactly when credit is available: FIFO occupancy plus reads in flight is less than FIFO_DEPTH.
REQ-028 Every bank SHALL receive the same row pointer on ram_read_addr; ram_read_addr SHALL hold its value when ram_re is 0.
REQ-029 For each issued read, the row pointer SHALL advance to pointer + stride, minus D if the sum is at least D; the sum is computed 33 bits wide with no overflow.
REQ-030 The FSM SHALL go ISSUE -> DRAIN on the cycle the last read is issued (issue counter reaches 0).
REQ-031 The RAM read latency is one cycle: ram_dout is captured into the FIFO when ram_dout_vld is 1, and no data is ever dropped.
REQ-032 The FIFO SHALL be first-word fall-through: m_valid equals "FIFO not empty" and m_data is the head entry.
REQ-033 A beat SHALL pop on a cycle where m_valid and m_ready are both 1.
REQ-034 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-035 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 m_last SHALL be 1 on the beat whose output count equals len.
REQ-037 The FSM SHALL go DRAIN -> IDLE on the m_last handshake, and done SHALL pulse on the following cycle.
REQ-038 busy SHALL be 1 in ISSUE and DRAIN, and 0 in IDLE.
REQ-039 m_valid SHALL NOT drop, and m_data SHALL NOT change, while m_valid is 1 and m_ready is 0.
REQ-040 Overflow SHALL be impossible by construction; an assertion SHALL flag a push when occupancy equals FIFO_DEPTH.
REQ-041 A ram_dout_vld with no read in flight SHALL be ignored.

Reset
REQ-042 While rst_n is 0, the FSM SHALL be IDLE, FIFO and counters cleared, and outputs set to: cmd_ready 1, ram_re 0, ram_read_addr 0, m_valid 0, m_last 0, busy 0, done 0.
REQ-043 Reset asserted mid-command SHALL abandon the command with no done pulse.
REQ-044 After reset, read data already in flight (ram_dout_vld 1 in the first cycle after reset) SHALL be ignored.

Verification
REQ-045 Scenario: base 0, stride 1, len 4, m_ready held 1 -> addresses 0, 1, 2, 3 on consecutive cycles; beats match RAM rows 0-3; m_last on beat 4; done one cycle after that beat.
REQ-046 Scenario: D 128, base 126, stride 3, len 3 -> addresses 126, 1, 4.
REQ-047 Scenario: len 8, m_ready held 0 -> exactly FIFO_DEPTH (4) reads issued, ram_re then held 0; releasing m_ready delivers all 8 beats in order with no loss.
REQ-048 Scenario: len 0 -> no ram_re, no m_valid; done pulses one cycle after acceptance.
REQ-049 Scenario: random m_ready toggling, len 16 -> m_data stays stable while stalled; exactly 16 beats with a single m_last.
REQ-050 Scenario: rst_n asserted in the middle of a len 10 command -> all outputs return to reset values; the next command runs correctly from its own base.

Source files
------------

// File: rtl/bank_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : bank_stream_reader_if
// Brief    : Command, banked-RAM read and output-stream signals of
//            bank_stream_reader, bundled with directional modports.
// Revision : 1.0 - initial release
// ============================================================================
interface bank_stream_reader_if #(
  parameter int NUM_RAMS = 8,
  parameter int W        = 128
);
  // command channel
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [31:0]             cmd_base;
  logic [31:0]             cmd_stride;
  logic [15:0]             cmd_len;
  // banked RAM read port
  logic                    ram_re;
  logic [NUM_RAMS*32-1:0]  ram_read_addr;
  logic                    ram_dout_vld;
  logic [NUM_RAMS*W-1:0]   ram_dout;
  // output stream and status
  logic                    m_valid;
  logic                    m_ready;
  logic [NUM_RAMS*W-1:0]   m_data;
  logic                    m_last;
  logic                    busy;
  logic                    done;

  // reader side
  modport slave (
    input  cmd_valid, cmd_base, cmd_stride, cmd_len,
    output cmd_ready,
    output ram_re, ram_read_addr,
    input  ram_dout_vld, ram_dout,
    output m_valid, m_data, m_last,
    input  m_ready,
    output busy, done
  );

  // environment side (command source, RAM, stream sink)
  modport master (
    output cmd_valid, cmd_base, cmd_stride, cmd_len,
    input  cmd_ready,
    input  ram_re, ram_read_addr,
    output ram_dout_vld, ram_dout,
    input  m_valid, m_data, m_last,
    output m_ready,
    input  busy, done
  );
endinterface
`default_nettype wire

// File: rtl/bank_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : bank_stream_reader
// Brief    : Reads len rows from a set of parallel RAM banks, walking the row
//            address by a stride modulo D, and streams each row out through a
//            small first-word fall-through buffer with credit-based issue.
// Revision : 1.0 - initial release
// ============================================================================
module bank_stream_reader #(
  parameter int NUM_RAMS   = 8,
  parameter int W          = 128,
  parameter int D          = 128,
  parameter int FIFO_DEPTH = 4
) (
  input wire                  clk,
  input wire                  rst_n,
  bank_stream_reader_if.slave bus
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_rw = NUM_RAMS * W;
  localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);
  localparam logic [c_cw-1:0] c_occ_one  = c_cw'(1);
  localparam logic [c_cw-1:0] c_occ_full = c_cw'(FIFO_DEPTH);
  localparam logic [32:0]     c_depth33  = 33'(D);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     ptr_q, ptr_d;
  logic [31:0]     stride_q, stride_d;
  logic [31:0]     addr_q, addr_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     issue_cnt_q, issue_cnt_d;
  logic [15:0]     out_cnt_q, out_cnt_d;
  logic            done_q, done_d;
  logic            inflight_q;
  logic [c_aw-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_cw-1:0] occ_q;
  logic [c_rw-1:0] mem_q [FIFO_DEPTH];

  logic            w_accept;
  logic            w_credit;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_last;
  logic [32:0]     w_sum;
  logic [31:0]     w_next_ptr;
  logic [31:0]     w_addr;

  assign w_accept = bus.cmd_valid && (state_q == IDLE);
  // Occupancy plus the (at most one) read in flight must leave a free slot.
  assign w_credit = (occ_q + {{(c_cw-1){1'b0}}, inflight_q}) < c_occ_full;
  assign w_issue  = (state_q == ISSUE) && w_credit;
  // Data arriving without a matching read in flight is discarded.
  assign w_push   = bus.ram_dout_vld && inflight_q;
  assign w_pop    = (occ_q != '0) && bus.m_ready;
  assign w_last   = (occ_q != '0) && (({1'b0, out_cnt_q} + 17'd1) == {1'b0, len_q});

  // Both operands are below D, so one conditional subtraction wraps the sum.
  assign w_sum      = {1'b0, ptr_q} + {1'b0, stride_q};
  assign w_next_ptr = (w_sum >= c_depth33) ? 32'(w_sum - c_depth33) : w_sum[31:0];

  // The address bus shows the row being read, otherwise the last row read.
  assign w_addr = w_issue ? ptr_q : addr_q;

  assign bus.cmd_ready     = (state_q == IDLE);
  assign bus.ram_re        = w_issue;
  assign bus.ram_read_addr = {NUM_RAMS{w_addr}};
  assign bus.m_valid       = (occ_q != '0);
  assign bus.m_data        = mem_q[rd_ptr_q];
  assign bus.m_last        = w_last;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;

  // Next-state logic for the command FSM and its counters.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    stride_d    = stride_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = w_pop ? (out_cnt_q + 16'd1) : out_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          ptr_d       = bus.cmd_base;
          stride_d    = bus.cmd_stride;
          len_d       = bus.cmd_len;
          issue_cnt_d = bus.cmd_len;
          out_cnt_d   = 16'd0;
          if (bus.cmd_len == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (w_issue) begin
          addr_d      = ptr_q;
          ptr_d       = w_next_ptr;
          issue_cnt_d = issue_cnt_q - 16'd1;
          if (issue_cnt_q == 16'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_pop && w_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      stride_q    <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      stride_q    <= stride_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      done_q      <= done_d;
      inflight_q  <= w_issue;
    end
  end

  // Buffer pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + c_ptr_one;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   occ_q <= occ_q + c_occ_one;
        2'b01:   occ_q <= occ_q - c_occ_one;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Buffer storage; contents are only meaningful below the occupancy mark.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= bus.ram_dout;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (occ_q == c_occ_full)));

endmodule
`default_nettype wire

// File: tb/tb_bank_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_stream_reader
// Brief    : Self-checking bench for bank_stream_reader: a command table plus
//            randomized commands, a RAM responder and a stream scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_stream_reader;

  localparam int NR = 4;
  localparam int WD = 16;
  localparam int DP = 128;
  localparam int FD = 4;
  localparam int RW = NR * WD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bank_stream_reader_if #(.NUM_RAMS(NR), .W(WD)) bus();

  bank_stream_reader #(.NUM_RAMS(NR), .W(WD), .D(DP), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM image and row assembly
  logic [WD-1:0] ram_img [DP][NR];

  function automatic logic [RW-1:0] row_of(input int r);
    logic [RW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*WD +: WD] = ram_img[r][i];
    return v;
  endfunction

  // RAM responder: one-cycle read latency, each bank uses its own address
  logic        pend = 1'b0;
  logic [31:0] pend_addr [NR];
  bit          inject = 1'b0;

  always @(negedge clk) begin
    pend = bus.ram_re;
    for (int i = 0; i < NR; i++) pend_addr[i] = bus.ram_read_addr[32*i +: 32];
  end

  always @(posedge clk) begin
    #1;
    bus.ram_dout_vld = pend | inject;
    for (int i = 0; i < NR; i++)
      bus.ram_dout[i*WD +: WD] = pend ? ram_img[int'(pend_addr[i] % DP)][i] : WD'($urandom);
  end

  // Downstream ready driver
  int     ready_pct   = 100;
  longint stall_until = 0;

  always @(posedge clk) begin
    #1;
    if ($time < stall_until) bus.m_ready = 1'b0;
    else                     bus.m_ready = (int'($urandom_range(99)) < ready_pct);
  end

  // Scoreboard: expected address/beat lists built from base + k*stride mod D
  int            cyc = 0;
  bit            mon_en = 1'b0;
  int            clr_gen = 0, seen_gen = 0;
  int            exp_addr [$];
  logic [RW-1:0] exp_beat [$];
  int            beat_idx = 0, cur_len = 0, issued = 0, popped = 0;
  int            acc_cnt = 0, done_cnt = 0, mlast_cnt = 0, done_exp = -100;
  int            first_iss = 0, last_iss = 0;
  logic [31:0]   last_addr = '0;
  bit            prev_stall = 1'b0;
  logic [RW-1:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n && mon_en) begin
      if (seen_gen != clr_gen) begin
        seen_gen = clr_gen;
        exp_addr.delete(); exp_beat.delete();
        beat_idx = 0; cur_len = 0; issued = 0; popped = 0;
        last_addr = '0; prev_stall = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.m_valid), 64'd1);
        chk("stall_data", bus.m_data, prev_data);
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_addr.delete(); exp_beat.delete();
        cur_len = int'(bus.cmd_len);
        for (int k = 0; k < cur_len; k++) begin
          int a;
          a = int'((longint'(bus.cmd_base) + longint'(k) * longint'(bus.cmd_stride)) % DP);
          exp_addr.push_back(a);
          exp_beat.push_back(row_of(a));
        end
        beat_idx = 0; issued = 0; popped = 0;
        acc_cnt++;
        if (cur_len == 0) done_exp = cyc + 1;
      end
      if (bus.ram_re) begin
        if (issued >= exp_addr.size()) begin
          chk("unexpected_re", 64'd1, 64'd0);
        end else begin
          chk("rd_addr", 64'(bus.ram_read_addr[31:0]), 64'(exp_addr[issued]));
          chk("credit", 64'((issued - popped) < FD), 64'd1);
        end
        for (int i = 1; i < NR; i++)
          chk("bank_addr_eq", 64'(bus.ram_read_addr[32*i +: 32]), 64'(bus.ram_read_addr[31:0]));
        if (issued == 0) first_iss = cyc;
        last_iss  = cyc;
        last_addr = bus.ram_read_addr[31:0];
        issued++;
      end else begin
        chk("addr_hold", 64'(bus.ram_read_addr[31:0]), 64'(last_addr));
      end
      if (bus.m_valid) begin
        if (beat_idx >= cur_len) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          chk("m_last", 64'(bus.m_last), 64'(beat_idx == cur_len - 1));
          if (bus.m_ready) begin
            chk("m_data", bus.m_data, exp_beat[beat_idx]);
            if (beat_idx == cur_len - 1) begin
              done_exp = cyc + 1;
              mlast_cnt++;
            end
            beat_idx++;
            popped++;
          end
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_time", 64'(cyc), 64'(done_exp));
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic check_rst(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, "_ram_re"},    64'(bus.ram_re), 64'd0);
    chk({tag, "_addr_zero"}, 64'(bus.ram_read_addr == '0), 64'd1);
    chk({tag, "_m_valid"},   64'(bus.m_valid), 64'd0);
    chk({tag, "_m_last"},    64'(bus.m_last), 64'd0);
    chk({tag, "_busy"},      64'(bus.busy), 64'd0);
    chk({tag, "_done"},      64'(bus.done), 64'd0);
  endtask

  task automatic send_cmd(input int base, input int stride, input int len, input string tag);
    int a0;
    bit ok;
    a0 = acc_cnt;
    ok = 1'b0;
    bus.cmd_base   = 32'(base);
    bus.cmd_stride = 32'(stride);
    bus.cmd_len    = 16'(len);
    bus.cmd_valid  = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      if (acc_cnt != a0) begin ok = 1'b1; break; end
    end
    #1 bus.cmd_valid = 1'b0;
    chk({tag, "_accept"}, 64'(ok), 64'd1);
  endtask

  task automatic run_cmd(input int base, input int stride, input int len, input int pct,
                         input int stall, input int exp_last, input string tag);
    int d0, ml0;
    bit ok;
    @(posedge clk); #1;
    ready_pct = pct;
    if (stall > 0) stall_until = $time + stall * 10;
    d0  = done_cnt;
    ml0 = mlast_cnt;
    send_cmd(base, stride, len, tag);
    if (stall > 0) begin
      repeat (stall - 6) @(posedge clk);
      #2;
      chk({tag, "_stall_issued"}, 64'(issued), 64'((len < FD) ? len : FD));
      chk({tag, "_stall_re"}, 64'(bus.ram_re), 64'd0);
    end
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    repeat (2) @(posedge clk);
    chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_beats"}, 64'(beat_idx), 64'(len));
    chk({tag, "_issued"}, 64'(issued), 64'(len));
    chk({tag, "_last_count"}, 64'(mlast_cnt - ml0), 64'((len > 0) ? 1 : 0));
    if (len > 0) chk({tag, "_final_addr"}, 64'(last_addr), 64'(exp_last));
    if (pct == 100 && stall == 0 && len > 0 && len <= FD)
      chk({tag, "_issue_span"}, 64'(last_iss - first_iss), 64'(len - 1));
  endtask

  typedef struct {
    int base;
    int stride;
    int len;
    int pct;
    int stall;
    int exp_last;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{base: 0,   stride: 1,   len: 4,  pct: 100, stall: 0,  exp_last: 3};
    vecs[1] = '{base: 126, stride: 3,   len: 3,  pct: 100, stall: 0,  exp_last: 4};
    vecs[2] = '{base: 10,  stride: 5,   len: 0,  pct: 100, stall: 0,  exp_last: 0};
    vecs[3] = '{base: 0,   stride: 1,   len: 8,  pct: 100, stall: 20, exp_last: 7};
    vecs[4] = '{base: 5,   stride: 127, len: 6,  pct: 50,  stall: 0,  exp_last: 0};
    vecs[5] = '{base: 100, stride: 64,  len: 5,  pct: 30,  stall: 0,  exp_last: 100};
    vecs[6] = '{base: 127, stride: 127, len: 16, pct: 50,  stall: 0,  exp_last: 112};
    vecs[7] = '{base: 0,   stride: 0,   len: 3,  pct: 100, stall: 0,  exp_last: 0};

    for (int r = 0; r < DP; r++)
      for (int i = 0; i < NR; i++) ram_img[r][i] = WD'($urandom);

    bus.cmd_valid  = 1'b0;
    bus.cmd_base   = '0;
    bus.cmd_stride = '0;
    bus.cmd_len    = '0;

    // power-on reset
    repeat (3) @(posedge clk);
    #2 check_rst("por");
    @(negedge clk);
    rst_n = 1'b1;
    clr_gen++;
    mon_en = 1'b1;

    // command table
    for (int v = 0; v < 8; v++)
      run_cmd(vecs[v].base, vecs[v].stride, vecs[v].len, vecs[v].pct,
              vecs[v].stall, vecs[v].exp_last, $sformatf("vec%0d", v));

    // stray read data while idle must not create a beat
    @(negedge clk); inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk("stray_vld_m_valid", 64'(bus.m_valid), 64'd0);

    // randomized commands
    for (int r = 0; r < 10; r++) begin
      int b, s, l, p;
      b = int'($urandom_range(DP - 1));
      s = int'($urandom_range(DP - 1));
      l = int'($urandom_range(20, 1));
      p = int'($urandom_range(100, 20));
      run_cmd(b, s, l, p, 0, int'((longint'(b) + longint'(l - 1) * longint'(s)) % DP),
              $sformatf("rnd%0d", r));
    end

    // reset in the middle of a len 10 command
    begin
      int d0;
      @(posedge clk); #1;
      ready_pct = 60;
      send_cmd(20, 7, 10, "midrst");
      repeat (6) @(posedge clk);
      #1;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #2 check_rst("midrst_in_reset");
      d0 = done_cnt;
      repeat (2) @(posedge clk);
      @(negedge clk); inject = 1'b1;
      @(negedge clk); inject = 1'b0;
      rst_n = 1'b1;
      clr_gen++;
      mon_en = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      chk("midrst_m_valid_after", 64'(bus.m_valid), 64'd0);
      chk("midrst_busy_after", 64'(bus.busy), 64'd0);
      chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
      run_cmd(40, 9, 5, 70, 0, 76, "postrst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
